// File: rtl/ctl_reg_reader.sv
// rtl/ctl_reg_reader.sv - controller-BRAM flag poller; optional STATE_WR write-back under CTL_FPGA_STATE_WR_EN
module ctl_reg_reader #(
    parameter int RD_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [7:0]  BRAM_ADDR,
    output logic [15:0] BRAM_DIN,
    output logic        BRAM_WE,
    input  logic [15:0] BRAM_DOUT,
    input  logic        THERMO,
    output logic        FORCE_FAN,
    output logic        MOD_UPDATE,
    output logic        MOD_REQ_RD_SEGMENT,
    output logic [31:0] MOD_CYCLE,
    output logic [63:0] MOD_FREQ_DIV,
    output logic [63:0] MOD_REP,
    output logic [7:0]  MOD_TRANSITION_MODE,
    output logic [63:0] MOD_TRANSITION_VALUE,
    output logic        SIL_UPDATE,
    output logic        SIL_MODE,
    output logic [31:0] SIL_RATE,
    output logic [31:0] SIL_STEPS
);

    typedef enum logic [2:0] {
        INIT,
        POLL,
        MOD_RD,
        SIL_RD,
        CLR
`ifdef CTL_FPGA_STATE_WR_EN
        , STATE_WR
`endif
    } state_t;

    // Where the FSM goes once a poll found nothing to do, or a clear-write finished.
`ifdef CTL_FPGA_STATE_WR_EN
    localparam state_t IDLE_NEXT = STATE_WR;
`else
    localparam state_t IDLE_NEXT = POLL;
`endif

    state_t              state_q;
    logic                init_step_q;
    logic [4:0]          issue_cnt_q;
    logic [4:0]          cap_cnt_q;
    logic [RD_LATENCY:0] pipe_q;
    logic [15:0]         flag_q;
    logic [15:0]         rd_buf_q [0:15];

    logic [7:0]          bram_addr_q;
    logic [15:0]         bram_din_q;
    logic                bram_we_q;
    logic                force_fan_q;
    logic                mod_update_q;
    logic                mod_seg_q;
    logic [31:0]         mod_cycle_q;
    logic [63:0]         mod_div_q;
    logic [63:0]         mod_rep_q;
    logic [7:0]          mod_tmode_q;
    logic [63:0]         mod_tval_q;
    logic                sil_update_q;
    logic                sil_mode_q;
    logic [31:0]         sil_rate_q;
    logic [31:0]         sil_steps_q;

    logic [4:0]          rd_len;
    logic [7:0]          rd_base;
    logic                issue_en;
    logic                cap_en;
    logic                cap_last;

    // Burst length and base address of the read run owned by the current state.
    always_comb begin
        rd_len  = 5'd0;
        rd_base = 8'h00;
        case (state_q)
            POLL: begin
                rd_len  = 5'd1;
                rd_base = 8'h00;
            end
            MOD_RD: begin
                rd_len  = 5'd16;
                rd_base = 8'h21;
            end
            SIL_RD: begin
                rd_len  = 5'd5;
                rd_base = 8'h40;
            end
            default: begin
                rd_len  = 5'd0;
                rd_base = 8'h00;
            end
        endcase
    end

    // Words come back in issue order, so a valid bit delayed by the BRAM latency marks each capture.
    assign issue_en = (issue_cnt_q < rd_len);
    assign cap_en   = pipe_q[RD_LATENCY];
    assign cap_last = cap_en && (cap_cnt_q == (rd_len - 5'd1));

    // Main FSM: issues pipelined reads, captures data, publishes settings and performs writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= INIT;
            init_step_q  <= 1'b0;
            issue_cnt_q  <= '0;
            cap_cnt_q    <= '0;
            pipe_q       <= '0;
            flag_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                rd_buf_q[i] <= '0;
            end
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            bram_we_q    <= 1'b0;
            force_fan_q  <= 1'b0;
            mod_update_q <= 1'b0;
            mod_seg_q    <= 1'b0;
            mod_cycle_q  <= '0;
            mod_div_q    <= '0;
            mod_rep_q    <= '0;
            mod_tmode_q  <= '0;
            mod_tval_q   <= '0;
            sil_update_q <= 1'b0;
            sil_mode_q   <= 1'b0;
            sil_rate_q   <= '0;
            sil_steps_q  <= '0;
        end else begin
            bram_we_q    <= 1'b0;
            bram_din_q   <= '0;
            mod_update_q <= 1'b0;
            sil_update_q <= 1'b0;

            for (int i = RD_LATENCY; i >= 1; i--) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pipe_q[0] <= issue_en;

            if (issue_en) begin
                bram_addr_q <= rd_base + {3'b000, issue_cnt_q};
                issue_cnt_q <= issue_cnt_q + 5'd1;
            end
            if (cap_en) begin
                rd_buf_q[cap_cnt_q[3:0]] <= BRAM_DOUT;
                cap_cnt_q                <= cap_cnt_q + 5'd1;
            end

            case (state_q)
                INIT: begin
                    bram_we_q <= 1'b1;
                    if (!init_step_q) begin
                        bram_addr_q <= 8'h02;
                        bram_din_q  <= 16'h0091;
                        init_step_q <= 1'b1;
                    end else begin
                        bram_addr_q <= 8'h03;
                        bram_din_q  <= 16'h0000;
                        init_step_q <= 1'b0;
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
                        state_q     <= POLL;
                    end
                end
                POLL: begin
                    if (cap_last) begin
                        flag_q      <= BRAM_DOUT;
                        force_fan_q <= BRAM_DOUT[13];
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
                        if (BRAM_DOUT[0]) begin
                            state_q <= MOD_RD;
                        end else if (BRAM_DOUT[2]) begin
                            state_q <= SIL_RD;
                        end else begin
                            state_q <= IDLE_NEXT;
                        end
                    end
                end
                MOD_RD: begin
                    // The last word bypasses the buffer so all fields change together with the strobe.
                    if (cap_last) begin
                        mod_update_q <= 1'b1;
                        mod_seg_q    <= rd_buf_q[0][0];
                        mod_cycle_q  <= {rd_buf_q[4], rd_buf_q[1]};
                        mod_div_q    <= {rd_buf_q[6], rd_buf_q[5], rd_buf_q[3], rd_buf_q[2]};
                        mod_rep_q    <= {rd_buf_q[10], rd_buf_q[9], rd_buf_q[8], rd_buf_q[7]};
                        mod_tmode_q  <= rd_buf_q[11][7:0];
                        mod_tval_q   <= {BRAM_DOUT, rd_buf_q[14], rd_buf_q[13], rd_buf_q[12]};
                        issue_cnt_q  <= '0;
                        cap_cnt_q    <= '0;
                        state_q      <= flag_q[2] ? SIL_RD : CLR;
                    end
                end
                SIL_RD: begin
                    if (cap_last) begin
                        sil_update_q <= 1'b1;
                        sil_mode_q   <= rd_buf_q[0][0];
                        sil_rate_q   <= {rd_buf_q[2], rd_buf_q[1]};
                        sil_steps_q  <= {BRAM_DOUT, rd_buf_q[3]};
                        issue_cnt_q  <= '0;
                        cap_cnt_q    <= '0;
                        state_q      <= CLR;
                    end
                end
                CLR: begin
                    // Only bits 0 and 2 can have been serviced to get here; everything else is written back.
                    bram_we_q   <= 1'b1;
                    bram_addr_q <= 8'h00;
                    bram_din_q  <= flag_q & 16'hFFFA;
                    issue_cnt_q <= '0;
                    cap_cnt_q   <= '0;
                    state_q     <= IDLE_NEXT;
                end
`ifdef CTL_FPGA_STATE_WR_EN
                STATE_WR: begin
                    bram_we_q   <= 1'b1;
                    bram_addr_q <= 8'h01;
                    bram_din_q  <= {8'h00, 1'b1, 6'b000000, THERMO};
                    issue_cnt_q <= '0;
                    cap_cnt_q   <= '0;
                    state_q     <= POLL;
                end
`endif
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign BRAM_ADDR            = bram_addr_q;
    assign BRAM_DIN             = bram_din_q;
    assign BRAM_WE              = bram_we_q;
    assign FORCE_FAN            = force_fan_q;
    assign MOD_UPDATE           = mod_update_q;
    assign MOD_REQ_RD_SEGMENT   = mod_seg_q;
    assign MOD_CYCLE            = mod_cycle_q;
    assign MOD_FREQ_DIV         = mod_div_q;
    assign MOD_REP              = mod_rep_q;
    assign MOD_TRANSITION_MODE  = mod_tmode_q;
    assign MOD_TRANSITION_VALUE = mod_tval_q;
    assign SIL_UPDATE           = sil_update_q;
    assign SIL_MODE             = sil_mode_q;
    assign SIL_RATE             = sil_rate_q;
    assign SIL_STEPS            = sil_steps_q;

endmodule

// File: tb/tb_ctl_reg_reader.sv
// tb/tb_ctl_reg_reader.sv - randomized self-checking bench for ctl_reg_reader
module tb_ctl_reg_reader;

    localparam int RD_LAT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        THERMO = 1'b0;
    logic [7:0]  BRAM_ADDR;
    logic [15:0] BRAM_DIN;
    logic        BRAM_WE;
    logic        FORCE_FAN;
    logic        MOD_UPDATE;
    logic        MOD_REQ_RD_SEGMENT;
    logic [31:0] MOD_CYCLE;
    logic [63:0] MOD_FREQ_DIV;
    logic [63:0] MOD_REP;
    logic [7:0]  MOD_TRANSITION_MODE;
    logic [63:0] MOD_TRANSITION_VALUE;
    logic        SIL_UPDATE;
    logic        SIL_MODE;
    logic [31:0] SIL_RATE;
    logic [31:0] SIL_STEPS;

    logic [15:0] mem [0:255];
    logic [15:0] rd1 = '0;
    logic [15:0] bram_dout = '0;

    int n_checks = 0;
    int n_errors = 0;

    ctl_reg_reader #(.RD_LATENCY(RD_LAT)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .BRAM_ADDR            (BRAM_ADDR),
        .BRAM_DIN             (BRAM_DIN),
        .BRAM_WE              (BRAM_WE),
        .BRAM_DOUT            (bram_dout),
        .THERMO               (THERMO),
        .FORCE_FAN            (FORCE_FAN),
        .MOD_UPDATE           (MOD_UPDATE),
        .MOD_REQ_RD_SEGMENT   (MOD_REQ_RD_SEGMENT),
        .MOD_CYCLE            (MOD_CYCLE),
        .MOD_FREQ_DIV         (MOD_FREQ_DIV),
        .MOD_REP              (MOD_REP),
        .MOD_TRANSITION_MODE  (MOD_TRANSITION_MODE),
        .MOD_TRANSITION_VALUE (MOD_TRANSITION_VALUE),
        .SIL_UPDATE           (SIL_UPDATE),
        .SIL_MODE             (SIL_MODE),
        .SIL_RATE             (SIL_RATE),
        .SIL_STEPS            (SIL_STEPS)
    );

    always #5 CLK = ~CLK;

    // Two-stage read-first BRAM model.
    always @(posedge CLK) begin
        rd1       <= mem[BRAM_ADDR];
        bram_dout <= rd1;
        if (BRAM_WE) mem[BRAM_ADDR] = BRAM_DIN;
    end

    // Event log gathered on the falling edge.
    int          cyc = 0;
    int          wr_c [$];
    logic [7:0]  wr_a [$];
    logic [15:0] wr_d [$];
    int          n_mod = 0, n_sil = 0, mod_cyc = 0, sil_cyc = 0, a21_cyc = 0;
    int          n_viol = 0, n_wr01_total = 0;
    logic        snap_seg, snap_smode;
    logic [31:0] snap_cycle, snap_srate, snap_ssteps;
    logic [63:0] snap_div, snap_rep, snap_tval;
    logic [7:0]  snap_tmode;
    logic [232:0] prev_mod = '0;
    logic        rst_prev = 1'b1;
    logic [7:0]  last_addr = '0;

    always @(negedge CLK) begin
        cyc++;
        if (BRAM_WE) begin
            wr_c.push_back(cyc);
            wr_a.push_back(BRAM_ADDR);
            wr_d.push_back(BRAM_DIN);
            if (BRAM_ADDR == 8'h01) n_wr01_total++;
        end else if (BRAM_DIN != 16'h0000) begin
            n_viol++;
        end
        if (MOD_UPDATE && SIL_UPDATE) n_viol++;
        if (MOD_UPDATE) begin
            n_mod++;
            mod_cyc    = cyc;
            snap_seg   = MOD_REQ_RD_SEGMENT;
            snap_cycle = MOD_CYCLE;
            snap_div   = MOD_FREQ_DIV;
            snap_rep   = MOD_REP;
            snap_tmode = MOD_TRANSITION_MODE;
            snap_tval  = MOD_TRANSITION_VALUE;
        end
        if (SIL_UPDATE) begin
            n_sil++;
            sil_cyc     = cyc;
            snap_smode  = SIL_MODE;
            snap_srate  = SIL_RATE;
            snap_ssteps = SIL_STEPS;
        end
        if (!rst_prev && !MOD_UPDATE &&
            ({MOD_REQ_RD_SEGMENT, MOD_CYCLE, MOD_FREQ_DIV, MOD_REP, MOD_TRANSITION_MODE, MOD_TRANSITION_VALUE} != prev_mod))
            n_viol++;
        prev_mod = {MOD_REQ_RD_SEGMENT, MOD_CYCLE, MOD_FREQ_DIV, MOD_REP, MOD_TRANSITION_MODE, MOD_TRANSITION_VALUE};
        if (!BRAM_WE && BRAM_ADDR == 8'h21 && last_addr != 8'h21) a21_cyc = cyc;
        last_addr = BRAM_ADDR;
        rst_prev  = RST;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        wr_c.delete();
        wr_a.delete();
        wr_d.delete();
        n_mod = 0;
        n_sil = 0;
        mod_cyc = 0;
        sil_cyc = 0;
        a21_cyc = 0;
    endtask

    function automatic int count_wr(input logic [7:0] a);
        int c = 0;
        foreach (wr_a[i]) if (wr_a[i] == a) c++;
        return c;
    endfunction

    function automatic logic [15:0] last_wr(input logic [7:0] a);
        logic [15:0] d = '0;
        foreach (wr_a[i]) if (wr_a[i] == a) d = wr_d[i];
        return d;
    endfunction

    function automatic logic [63:0] word4(input logic [7:0] a);
        // Four consecutive words, lowest address in the least-significant position.
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic run_flag(input logic [15:0] flag, input logic th, input bit directed);
        logic [15:0] exp_clr;
        bit          svc;
        int          k;
        for (int a = 8'h21; a <= 8'h30; a++) mem[a] = 16'($urandom);
        for (int a = 8'h40; a <= 8'h44; a++) mem[a] = 16'($urandom);
        if (directed) begin
            mem[8'h23] = 16'h5678;
            mem[8'h24] = 16'h1234;
        end
        THERMO = th;
        clear_log();
        mem[8'h00] = flag;
        svc = (flag[0] || flag[2]);
        if (svc) begin
            k = 0;
            while (count_wr(8'h00) == 0 && k < 200) begin
                tick(1);
                k++;
            end
            check_val("svc_done", 64'(count_wr(8'h00) != 0), 1);
            tick(5);
        end else begin
            tick(60);
        end

        check_val("mod_upd_cnt", 64'(n_mod), 64'(flag[0]));
        if (flag[0]) begin
            check_val("mod_latency", 64'(mod_cyc - a21_cyc), 64'(16 + RD_LAT));
            check_val("mod_seg", 64'(snap_seg), 64'(mem[8'h21][0]));
            check_val("mod_cycle", 64'(snap_cycle), {32'h0, mem[8'h25], mem[8'h22]});
            check_val("mod_div", snap_div, {word4(8'h26) & 64'hFFFF_FFFF, 32'h0} | (word4(8'h23) & 64'hFFFF_FFFF));
            check_val("mod_rep", snap_rep, word4(8'h28));
            check_val("mod_tmode", 64'(snap_tmode), 64'(mem[8'h2C][7:0]));
            check_val("mod_tval", snap_tval, word4(8'h2D));
            if (directed) check_val("mod_div_lo", 64'(snap_div[31:0]), 64'h1234_5678);
        end
        check_val("sil_upd_cnt", 64'(n_sil), 64'(flag[2]));
        if (flag[2]) begin
            check_val("sil_mode", 64'(snap_smode), 64'(mem[8'h40][0]));
            check_val("sil_rate", 64'(snap_srate), {32'h0, mem[8'h42], mem[8'h41]});
            check_val("sil_steps", 64'(snap_ssteps), {32'h0, mem[8'h44], mem[8'h43]});
        end
        if (flag[0] && flag[2]) check_val("sil_after_mod_gap", 64'((sil_cyc - mod_cyc) >= 6), 1);

        exp_clr = flag;
        if (flag[0]) exp_clr[0] = 1'b0;
        if (flag[2]) exp_clr[2] = 1'b0;
        check_val("clr_wr_cnt", 64'(count_wr(8'h00)), svc ? 64'd1 : 64'd0);
        if (svc) check_val("clr_wr_data", 64'(last_wr(8'h00)), 64'(exp_clr));
        check_val("force_fan", 64'(FORCE_FAN), 64'(flag[13]));
`ifdef CTL_FPGA_STATE_WR_EN
        check_val("state_wr_seen", 64'(count_wr(8'h01) >= 1), 1);
        check_val("state_wr_data", 64'(last_wr(8'h01)), 64'({8'h00, 1'b1, 6'b0, th}));
`else
        check_val("no_state_wr", 64'(count_wr(8'h01)), 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int a = 0; a < 256; a++) mem[a] = '0;

        // Reset and INIT writes.
        RST = 1'b1;
        tick(3);
        check_val("rst_outputs_zero", 64'(|{BRAM_ADDR, BRAM_DIN, BRAM_WE, FORCE_FAN, MOD_UPDATE, MOD_REQ_RD_SEGMENT,
                                           MOD_CYCLE, MOD_FREQ_DIV, MOD_REP, MOD_TRANSITION_MODE, MOD_TRANSITION_VALUE,
                                           SIL_UPDATE, SIL_MODE, SIL_RATE, SIL_STEPS}), 0);
        clear_log();
        RST = 1'b0;
        tick(4);
        check_val("init_wr_cnt", 64'(wr_a.size() >= 2), 1);
        if (wr_a.size() >= 2) begin
            check_val("init_wr0_addr", 64'(wr_a[0]), 64'h02);
            check_val("init_wr0_data", 64'(wr_d[0]), 64'h0091);
            check_val("init_wr1_addr", 64'(wr_a[1]), 64'h03);
            check_val("init_wr1_data", 64'(wr_d[1]), 64'h0000);
            check_val("init_wr_consec", 64'(wr_c[1] - wr_c[0]), 1);
        end
        check_val("post_init_mod_zero", 64'(|{MOD_CYCLE, MOD_FREQ_DIV, MOD_REP, SIL_RATE, SIL_STEPS, FORCE_FAN}), 0);

        // Directed cases followed by random flag words.
        run_flag(16'h0001, 1'b0, 1'b1);
        run_flag(16'h2005, 1'b0, 1'b0);
        run_flag(16'h0004, 1'b1, 1'b0);
        run_flag(16'h0000, 1'b1, 1'b0);
        for (int t = 0; t < 6; t++) run_flag(16'($urandom), 1'($urandom), 1'b0);
        run_flag(16'h0001, 1'b0, 1'b1);

        // Reset pulse while the eighth modulation word is being addressed.
        clear_log();
        mem[8'h00] = 16'h0001;
        k = 0;
        while (BRAM_ADDR != 8'h28 && k < 100) begin
            tick(1);
            k++;
        end
        check_val("rst_mid_reach_w8", 64'(BRAM_ADDR == 8'h28), 1);
        RST = 1'b1;
        mem[8'h00] = 16'h0000;
        clear_log();
        tick(1);
        RST = 1'b0;
        tick(60);
        check_val("rst_mid_no_mod_upd", 64'(n_mod), 0);
        check_val("rst_mid_no_clr", 64'(count_wr(8'h00)), 0);
        check_val("rst_mid_init_rerun", 64'(wr_a.size() >= 2 && wr_a[0] == 8'h02 && wr_a[1] == 8'h03), 1);
        check_val("rst_mid_div_zero", MOD_FREQ_DIV, 0);
        check_val("rst_mid_fan_zero", 64'(FORCE_FAN), 0);

        check_val("protocol_violations", 64'(n_viol), 0);
`ifndef CTL_FPGA_STATE_WR_EN
        check_val("no_wr01_total", 64'(n_wr01_total), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctl_reg_reader.md
CTL_REG_READER -- requirements
Module: ctl_reg_reader

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 2: controller-BRAM read latency in cycles, address to data.
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1: sole clock.
- RST  in  1: synchronous, active-high reset.
- BRAM_ADDR  out  8: controller-BRAM port-B address.
- BRAM_DIN  out  16: write data.
- BRAM_WE  out  1: write enable.
- BRAM_DOUT  in  16: read data.
- THERMO  in  1: thermal-alarm input.
- FORCE_FAN  out  1: fan-force flag.
- MOD_UPDATE  out  1: one-cycle modulation-settings-valid strobe.
- MOD_REQ_RD_SEGMENT  out  1: requested modulation segment.
- MOD_CYCLE  out  32: {cycle1, cycle0}.
- MOD_FREQ_DIV  out  64: {div1, div0}.
- MOD_REP  out  64: {rep1, rep0}.
- MOD_TRANSITION_MODE  out  8: transition mode.
- MOD_TRANSITION_VALUE  out  64: transition value.
- SIL_UPDATE  out  1: one-cycle silencer-settings-valid strobe.
- SIL_MODE  out  1: silencer mode.
- SIL_RATE  out  32: {phase, intensity} update rates.
- SIL_STEPS  out  32: {phase, intensity} completion steps.

Function
REQ-003 SHALL use FSM states INIT, POLL, MOD_RD, SIL_RD, CLR, STATE_WR.
REQ-004 INIT SHALL write 0x0091 to 0x02 and 0x0000 to 0x03 on two consecutive cycles, then enter POLL.
REQ-005 POLL SHALL read 0x00, capture the word after RD_LATENCY cycles, and update FORCE_FAN from bit 13 on each poll.
REQ-006 When captured bit 0 (MOD_SET) is set, the FSM SHALL enter MOD_RD; otherwise, when bit 2 (SILENCER_SET) is set, it SHALL enter SIL_RD; otherwise it SHALL enter STATE_WR if compiled in, else POLL.
REQ-007 MOD_RD SHALL issue addresses 0x21 to 0x30 on 16 consecutive cycles, pipelined, and capture each word RD_LATENCY cycles after its address.
REQ-008 MOD_RD field mapping: 0x21 bit 0 to REQ_RD_SEGMENT; 0x22/0x25 to cycle0/1; 0x23,0x24 / 0x26,0x27 to div0/div1; 0x28,0x29 / 0x2A,0x2B to rep0/rep1; 0x2C[7:0] to TRANSITION_MODE; 0x2D..0x30 to TRANSITION_VALUE. Lower address = less-significant 16 bits.
REQ-009 MOD_UPDATE SHALL pulse exactly 1 cycle after the last word is captured, i.e. 16+RD_LATENCY+1 cycles after MOD_RD entry; MOD_* outputs SHALL change only in that cycle.
REQ-010 After MOD_RD, the FSM SHALL enter SIL_RD if captured bit 2 is set, else CLR.
REQ-011 SIL_RD SHALL read 0x40 to 0x44 pipelined (5 issue cycles) with mapping 0x40 bit 0 to SIL_MODE, {0x42,0x41} to SIL_RATE, {0x44,0x43} to SIL_STEPS, then pulse SIL_UPDATE 1 cycle after the final capture and enter CLR.
REQ-012 CLR SHALL perform one write to 0x00 of the captured flag word with the serviced bits 0 and/or 2 cleared and all other bits unchanged.
REQ-013 BRAM_WE SHALL be high only in INIT, CLR and STATE_WR write cycles; BRAM_DIN SHALL be 0 whenever BRAM_WE is low.
REQ-014 The block SHALL hold no outstanding read when leaving a read state: all in-flight data SHALL be drained before the state transition.
REQ-015 MOD_UPDATE and SIL_UPDATE SHALL never be high in the same cycle.

Reset
REQ-016 On RST, the FSM SHALL enter INIT, all outputs and captured registers SHALL be 0, and in-flight reads SHALL be discarded.
REQ-017 RST asserted mid-sequence SHALL suppress any pending UPDATE strobe and CLR write.

Configuration
REQ-018 With macro CTL_FPGA_STATE_WR_EN defined, STATE_WR SHALL write {8'h00, 1'b1, 6'b0, THERMO} to 0x01 once per poll cycle, after CLR or after a poll with no set bits, then enter POLL.
REQ-019 Without CTL_FPGA_STATE_WR_EN, STATE_WR SHALL not exist, the block SHALL never write 0x01, and CLR and POLL SHALL transition directly to POLL.

Verification
REQ-020 Release reset -> writes (0x02, 0x0091) then (0x03, 0x0000) on consecutive cycles; all outputs 0.
REQ-021 Flag 0x0001 with 0x23=0x5678 and 0x24=0x1234 -> one MOD_UPDATE with MOD_FREQ_DIV[31:0]=0x12345678, then write (0x00, 0x0000).
REQ-022 Flag 0x2005 -> MOD_UPDATE, then SIL_UPDATE at least 6 cycles later, then a single write (0x00, 0x2000); FORCE_FAN=1.
REQ-023 RST pulsed during MOD_RD word 8 -> no MOD_UPDATE, no CLR write, INIT rerun.
REQ-024 With CTL_FPGA_STATE_WR_EN, THERMO=1 and flag 0x0000 -> repeated writes (0x01, 0x0081); without the macro -> no write to 0x01.
